// File: rtl/stack_arb_pkg.sv
// Shared types for the two-requester stack controller: op encoding and its decoder.
package stack_arb_pkg;

    localparam int REQ_N = 2;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic push, input logic pop);
        op_e op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_SWAP;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: picks one requester, alternating on contention.
// Latency: select is combinational; last_grant moves on the edge when advance is set.
// Backpressure: none; the loser simply holds its request and wins next contention.
module rr_arb2
    import stack_arb_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             advance,
    output logic [REQ_N-1:0] sel
);

    // 1 = requester 1 was last selected, so requester 0 wins the first contention
    logic last_grant;

    always_comb begin
        sel = '0;
        if (req0 && req1) begin
            sel = last_grant ? 2'b01 : 2'b10;
        end else begin
            sel = {req1, req0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance && (req0 || req1)) begin
            last_grant <= sel[1];
        end
    end

endmodule

// File: rtl/stack_arb_ctrl.sv
// Shared LIFO stack with two push/pop/swap requesters under round-robin arbitration.
// Latency: grant combinational; pop data one cycle after an accepted pop or swap.
// Backpressure: push on full / pop or swap on empty is refused (grant=00) with an error pulse.
module stack_arb_ctrl
    import stack_arb_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int WIDTH      = 8,
    parameter  int HIGH_WATER = 6,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             req0_push,
    input  logic             req0_pop,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_push,
    input  logic             req1_pop,
    input  logic [WIDTH-1:0] req1_data,
    output logic [1:0]       grant,
    output logic             pop_valid,
    output logic             pop_src,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             high_water,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    op_e              op0;
    op_e              op1;
    op_e              sel_op;
    logic [REQ_N-1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic             ovf_hit;
    logic             unf_hit;
    logic             accept;
    logic             reads_top;
    logic [AW-1:0]    push_addr;
    logic [AW-1:0]    top_addr;

    assign op0 = decode_op(req0_push, req0_pop);
    assign op1 = decode_op(req1_push, req1_pop);

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req0    (op0 != OP_NONE),
        .req1    (op1 != OP_NONE),
        .advance (enable),
        .sel     (sel)
    );

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign high_water = (HIGH_WATER != 0) && (count >= CNT_W'(HIGH_WATER));

    // Addresses only used under the full/empty guards, so truncation is safe
    assign push_addr = AW'(count);
    assign top_addr  = AW'(count - CNT_W'(1));

    always_comb begin
        sel_op    = OP_NONE;
        sel_data  = req0_data;
        if (sel[1]) begin
            sel_op   = op1;
            sel_data = req1_data;
        end else if (sel[0]) begin
            sel_op   = op0;
        end
        ovf_hit   = enable && (sel_op == OP_PUSH) && full;
        unf_hit   = enable && ((sel_op == OP_POP) || (sel_op == OP_SWAP)) && empty;
        accept    = enable && (sel_op != OP_NONE) && !ovf_hit && !unf_hit;
        reads_top = accept && (sel_op != OP_PUSH);
        grant     = accept ? sel : 2'b00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            pop_valid <= 1'b0;
            pop_src   <= 1'b0;
            pop_data  <= '0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            ovf_err   <= ovf_hit;
            unf_err   <= unf_hit;
            pop_valid <= reads_top;
            if (reads_top) begin
                pop_src  <= sel[1];
                pop_data <= mem[top_addr];
            end
            if (accept && (sel_op == OP_PUSH)) begin
                count <= count + CNT_W'(1);
            end else if (accept && (sel_op == OP_POP)) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clock) begin
        if (!reset && accept && (sel_op == OP_PUSH)) begin
            mem[push_addr] <= sel_data;
        end else if (!reset && accept && (sel_op == OP_SWAP)) begin
            mem[top_addr] <= sel_data;
        end
    end

endmodule

// File: doc/stack_arb_ctrl.md
Name: stack_arb_ctrl

Overview:
- Controller that owns a LIFO register-array stack and shares it between two requesters.
- Each requester issues push, pop or swap operations. A round-robin arbiter grants at most one operation per cycle.
- Produces the full, empty, pop and status signals that an ovl_stack checker instance in the same design monitors.
- Sits between two producer/consumer engines and the shared scratch stack.

Parameters:
- DEPTH, 8, number of stack entries (>=2).
- WIDTH, 8, data word width.
- HIGH_WATER, 6, count at or above which high_water asserts (0 disables; must be <=DEPTH).
- CNT_W, $clog2(DEPTH+1), count width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global qualifier; low freezes all state
- req0_push  in  1  requester 0 push request
- req0_pop  in  1  requester 0 pop request
- req0_data  in  WIDTH  requester 0 push data
- req1_push  in  1  requester 1 push request
- req1_pop  in  1  requester 1 pop request
- req1_data  in  WIDTH  requester 1 push data
- grant  out  2  one-hot grant of the accepted operation (combinational from requests and state)
- pop_valid  out  1  pop_data valid (registered)
- pop_src  out  1  requester that owns pop_data
- pop_data  out  WIDTH  popped word
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  CNT_W  current occupancy
- high_water  out  1  HIGH_WATER!=0 and count>=HIGH_WATER
- ovf_err  out  1  one-cycle pulse: push rejected on full
- unf_err  out  1  one-cycle pulse: pop rejected on empty

Behaviour:
- Clock and reset: reset is synchronous, active-high, single clock `clock`.
- Reset values:
  - count=0, empty=1, full=0, high_water=0.
  - pop_valid=0, pop_src=0, pop_data=0, ovf_err=0, unf_err=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Storage array is not reset.
- Operation per requester (push/pop bits):
  - 00 = none.
  - 10 = push.
  - 01 = pop.
  - 11 = swap: pop_data returns the old top, the top entry is overwritten with req data, count is unchanged.
- Requesting: a requester with a non-zero op is "requesting"; requests are level, sampled every cycle.
- Arbitration (enable=1):
  - One requester requesting: it is selected.
  - Both requesting: select the one that is not last_grant.
  - last_grant updates to the selected requester, whether or not the operation is accepted.
- Acceptance:
  - Push on full: rejected.
  - Pop on empty: rejected.
  - Swap on empty: rejected as underflow.
  - Swap on full: accepted.
  - Rejected: grant=00 and the corresponding err pulses the next cycle. Stack state unchanged.
  - Accepted: grant one-hot for the selected requester in the same cycle. State updates at the clock edge.
- Storage:
  - Push writes mem[count] and count+1.
  - Pop reads mem[count-1] and count-1.
  - Swap reads mem[count-1] and writes mem[count-1] with the new data.
- Pop latency 1: pop_valid=1 in the cycle after an accepted pop or swap, with pop_src and pop_data. Otherwise pop_valid=0.
- Status flags: full, empty and high_water are derived from registered count. They reflect the updated count in the cycle after the operation.
- enable=0:
  - grant=00, no state change, no err pulses, last_grant held.
  - pop_valid deasserts the next cycle; pop_data holds.
- Back-to-back: an operation is possible every cycle. A pop in the cycle after a push returns the just-pushed word (no bypass hazard, since the write occurs at the edge).
- The non-selected requester must hold its request. It is never granted in a cycle it was not selected.
- Reset asserted mid-operation: any pending pop_valid is cancelled next cycle and the stack is empty.
- Arithmetic: count never wraps. Guards are the only protection; there is no modulo arithmetic.

Decomposition:
- Package stack_arb_pkg:
  - op enum: OP_NONE, OP_PUSH, OP_POP, OP_SWAP.
  - Function decoding the {push,pop} pair into op.
  - Localparam REQ_N=2.
- Sub-module rr_arb2:
  - Two request inputs, advance strobe, one-hot select output, internal last_grant register.
  - Sync active-high reset on the same clock and reset.
- Storage, count and pop pipeline stay in stack_arb_ctrl.

Test Plan:
- Reset, then req0 pushes 0x11, 0x22, 0x33 on consecutive cycles:
  - grant=01 each cycle.
  - count goes 1, 2, 3.
  - empty drops after the first push.
- Both requesters pop simultaneously with 3 entries after the last grant went to req0:
  - req1 is granted first and receives 0x33 (pop_src=1).
  - Next cycle req0 is granted and receives 0x22.
- DEPTH=8 stack filled to 8, then req1 pushes 0x55:
  - full=1, grant=00, ovf_err pulses 1 cycle, count stays 8.
- Empty stack, req0 pops:
  - unf_err pulses, pop_valid=0.
- req0 swaps 0x77 onto top 0x44:
  - pop_data=0x44 next cycle, count unchanged.
  - A subsequent pop returns 0x77.
- Pushes to count 6 with HIGH_WATER=6:
  - high_water=1.
  - Then with enable=0 for 3 cycles while both requesting: no grants, count=6.
  - reset mid-stream: count=0, pop_valid=0 next cycle.
